// File: rtl/rv32im_mem_pkg.sv
// Shared types and helpers for the rv32im pipelined Wishbone memory stage.
// Size encodings, FSM states, pending-entry layout, lane helpers.
package rv32im_mem_pkg;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SEL_W  = 4;
    localparam int unsigned OFF_W  = 2;
    localparam int unsigned SIZE_W = 2;
    localparam int unsigned PEND_W = OFF_W + SIZE_W + 2;

    typedef enum logic [SIZE_W-1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10,
        SIZE_ILL  = 2'b11
    } mem_size_e;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_ACTIVE   = 2'b01,
        ST_ERRFLUSH = 2'b10
    } mem_state_e;

    // One in-flight transaction: what is needed to shape its response.
    typedef struct packed {
        logic [OFF_W-1:0] off;
        mem_size_e        size;
        logic             uns;
        logic             wr;
    } pend_t;

    function automatic logic is_misaligned(input mem_size_e size, input logic [OFF_W-1:0] off);
        case (size)
            SIZE_BYTE: return 1'b0;
            SIZE_HALF: return off[0];
            SIZE_WORD: return off != 2'b00;
            default:   return 1'b1;
        endcase
    endfunction

    function automatic logic [SEL_W-1:0] sel_of(input mem_size_e size, input logic [OFF_W-1:0] off);
        case (size)
            SIZE_BYTE: return 4'b0001 << off;
            SIZE_HALF: return off[1] ? 4'b1100 : 4'b0011;
            default:   return 4'b1111;
        endcase
    endfunction

    function automatic logic [DATA_W-1:0] replicate(input mem_size_e size, input logic [DATA_W-1:0] d);
        case (size)
            SIZE_BYTE: return {4{d[7:0]}};
            SIZE_HALF: return {2{d[15:0]}};
            default:   return d;
        endcase
    endfunction

    // Lane-shift the read word down to bit 0, then sign/zero extend.
    function automatic logic [DATA_W-1:0] extend(input pend_t p, input logic [DATA_W-1:0] dat);
        logic [DATA_W-1:0] sh;
        sh = dat >> {p.off, 3'b000};
        if (p.wr) return '0;
        case (p.size)
            SIZE_BYTE: return p.uns ? {24'b0, sh[7:0]}  : {{24{sh[7]}}, sh[7:0]};
            SIZE_HALF: return p.uns ? {16'b0, sh[15:0]} : {{16{sh[15]}}, sh[15:0]};
            default:   return sh;
        endcase
    endfunction

endpackage

// File: rtl/rv32im_pending_fifo.sv
// Synchronous FIFO of pending-transaction descriptors, with flush.
// Push and pop may coincide, including when full.
module rv32im_pending_fifo
    import rv32im_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = PEND_W
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         push_data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_c,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_c,
    output logic                     empty_c
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    assign head_c  = mem[rd_ptr];
    assign full_c  = count_o == CW'(DEPTH);
    assign empty_c = count_o == CW'(0);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else if (flush_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_o <= '0;
        end else begin
            if (push_i) wr_ptr <= wr_ptr + AW'(1);
            if (pop_i)  rd_ptr <= rd_ptr + AW'(1);
            count_o <= count_o + CW'(push_i) - CW'(pop_i);
        end
    end

    // Storage needs no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk_i) begin
        if (push_i && !flush_i) mem[wr_ptr] <= push_data_i;
    end

endmodule

// File: rtl/rv32im_memory_pipe.sv
// Pipelined Wishbone B4 master for the rv32im memory stage: up to DEPTH
// transfers in flight, in-order responses, misalignment trapped locally.
module rv32im_memory_pipe
    import rv32im_mem_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned DEPTH = 4
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            clear_i,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_data_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic            req_write_i,
    output logic            rsp_valid_o,
    output logic [XLEN-1:0] rsp_data_o,
    output logic            rsp_err_o,
    output logic            rsp_misaligned_o,
    output logic            busy_o,
    output logic            cyc_o,
    output logic            stb_o,
    output logic            we_o,
    output logic [XLEN-3:0] adr_o,
    output logic [3:0]      sel_o,
    output logic [XLEN-1:0] master_dat_o,
    input  logic [XLEN-1:0] master_dat_i,
    input  logic            ack_i,
    input  logic            err_i,
    input  logic            stall_i
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;

    mem_state_e        state_q, state_d;
    logic              run_q;
    logic              cyc_d, stb_d, we_d, busy_d;
    logic [XLEN-3:0]   adr_d;
    logic [3:0]        sel_d;
    logic [XLEN-1:0]   dat_d;
    logic              rsp_valid_d, rsp_err_d, rsp_mis_d;
    logic [XLEN-1:0]   rsp_data_d;

    logic [CW-1:0]     count;
    logic              fifo_full, fifo_empty, fifo_flush;
    logic [PEND_W-1:0] head_bits, req_pend;
    pend_t             head;
    mem_size_e         req_size;
    logic              req_mis, err_hit, ack_hit, accept, accept_bus;

    assign req_size   = mem_size_e'(req_size_i);
    assign req_mis    = is_misaligned(req_size, req_addr_i[1:0]);
    assign req_pend   = {req_addr_i[1:0], req_size_i, req_unsigned_i, req_write_i};
    assign head       = pend_t'(head_bits);
    assign err_hit    = err_i & !fifo_empty;
    assign ack_hit    = ack_i & !fifo_empty & !err_i;
    assign fifo_flush = clear_i | err_hit;
    assign accept     = req_valid_i & req_ready_o;
    assign accept_bus = accept & !req_mis;

    // Ready also drops under err/clear so an accept is never silently flushed.
    always_comb begin
        req_ready_o = run_q & (state_q != ST_ERRFLUSH) & !clear_i & !err_hit
                    & !fifo_full & (!stb_o | !stall_i);
        if (req_mis && (count != CW'(0) || stb_o)) req_ready_o = 1'b0;
    end

    rv32im_pending_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PEND_W)
    ) u_pend (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .flush_i     (fifo_flush),
        .push_i      (accept_bus),
        .push_data_i (req_pend),
        .pop_i       (ack_hit),
        .head_c      (head_bits),
        .count_o     (count),
        .full_c      (fifo_full),
        .empty_c     (fifo_empty)
    );

    always_comb begin
        state_d     = state_q;
        cyc_d       = cyc_o;
        stb_d       = stb_o;
        we_d        = we_o;
        adr_d       = adr_o;
        sel_d       = sel_o;
        dat_d       = master_dat_o;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_mis_d   = 1'b0;
        rsp_data_d  = '0;

        if (clear_i) begin
            state_d = ST_IDLE;
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            we_d    = 1'b0;
            sel_d   = '0;
        end else if (err_hit) begin
            state_d     = ST_ERRFLUSH;
            cyc_d       = 1'b0;
            stb_d       = 1'b0;
            we_d        = 1'b0;
            sel_d       = '0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
        end else begin
            if (ack_hit) begin
                rsp_valid_d = 1'b1;
                rsp_data_d  = extend(head, master_dat_i);
            end
            if (stb_o && !stall_i) stb_d = 1'b0;
            if (accept && req_mis) begin
                rsp_valid_d = 1'b1;
                rsp_mis_d   = 1'b1;
            end
            if (accept_bus) begin
                state_d = ST_ACTIVE;
                cyc_d   = 1'b1;
                stb_d   = 1'b1;
                we_d    = req_write_i;
                adr_d   = req_addr_i[XLEN-1:2];
                sel_d   = sel_of(req_size, req_addr_i[1:0]);
                dat_d   = replicate(req_size, req_data_i);
            end else begin
                case (state_q)
                    ST_ERRFLUSH: state_d = ST_IDLE;
                    ST_ACTIVE: begin
                        if (fifo_empty && !stb_o) begin
                            state_d = ST_IDLE;
                            cyc_d   = 1'b0;
                            we_d    = 1'b0;
                            sel_d   = '0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        busy_d = cyc_d | rsp_valid_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q          <= ST_IDLE;
            run_q            <= 1'b0;
            cyc_o            <= 1'b0;
            stb_o            <= 1'b0;
            we_o             <= 1'b0;
            adr_o            <= '0;
            sel_o            <= '0;
            master_dat_o     <= '0;
            rsp_valid_o      <= 1'b0;
            rsp_err_o        <= 1'b0;
            rsp_misaligned_o <= 1'b0;
            rsp_data_o       <= '0;
            busy_o           <= 1'b0;
        end else begin
            state_q          <= state_d;
            run_q            <= 1'b1;
            cyc_o            <= cyc_d;
            stb_o            <= stb_d;
            we_o             <= we_d;
            adr_o            <= adr_d;
            sel_o            <= sel_d;
            master_dat_o     <= dat_d;
            rsp_valid_o      <= rsp_valid_d;
            rsp_err_o        <= rsp_err_d;
            rsp_misaligned_o <= rsp_mis_d;
            rsp_data_o       <= rsp_data_d;
            busy_o           <= busy_d;
        end
    end

endmodule

// File: tb/tb_rv32im_memory_pipe.sv
// Bench for rv32im_memory_pipe: directed cases plus a randomized run
// against a transaction-level model of the master and a Wishbone slave.
module tb_rv32im_memory_pipe;

    localparam int DEPTH = 4;
    localparam int NRAND = 400;

    logic        clk_i = 1'b0;
    logic        rst_n_i, clear_i, req_valid_i, req_ready_o;
    logic [31:0] req_addr_i, req_data_i;
    logic [1:0]  req_size_i;
    logic        req_unsigned_i, req_write_i;
    logic        rsp_valid_o, rsp_err_o, rsp_misaligned_o, busy_o;
    logic [31:0] rsp_data_o;
    logic        cyc_o, stb_o, we_o;
    logic [29:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] master_dat_o, master_dat_i;
    logic        ack_i, err_i, stall_i;

    int n_vec = 0;
    int n_err = 0;

    rv32im_memory_pipe #(.XLEN(32), .DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_n_i(rst_n_i), .clear_i(clear_i),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_addr_i(req_addr_i), .req_data_i(req_data_i), .req_size_i(req_size_i),
        .req_unsigned_i(req_unsigned_i), .req_write_i(req_write_i),
        .rsp_valid_o(rsp_valid_o), .rsp_data_o(rsp_data_o), .rsp_err_o(rsp_err_o),
        .rsp_misaligned_o(rsp_misaligned_o), .busy_o(busy_o),
        .cyc_o(cyc_o), .stb_o(stb_o), .we_o(we_o), .adr_o(adr_o), .sel_o(sel_o),
        .master_dat_o(master_dat_o), .master_dat_i(master_dat_i),
        .ack_i(ack_i), .err_i(err_i), .stall_i(stall_i)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    // Reference rules, expressed arithmetically.
    function automatic bit ref_mis(input int size, input logic [31:0] a);
        return size == 3 || (size == 1 && a % 2 != 0) || (size == 2 && a % 4 != 0);
    endfunction

    function automatic logic [3:0] ref_sel(input int size, input logic [31:0] a);
        if (size == 0) return 4'(1 << (a % 4));
        if (size == 1) return (a % 4 >= 2) ? 4'hC : 4'h3;
        return 4'hF;
    endfunction

    function automatic logic [31:0] ref_wdat(input int size, input logic [31:0] d);
        if (size == 0) return (d % 256) * 32'h0101_0101;
        if (size == 1) return (d % 65536) * 32'h0001_0001;
        return d;
    endfunction

    function automatic logic [31:0] ref_load(input int size, input bit uns, input logic [31:0] a,
                                             input logic [31:0] rd);
        logic [31:0] v;
        v = rd >> ((a % 4) * 8);
        if (size == 0) begin
            v = v % 256;
            if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v % 65536;
            if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
        end
        return v;
    endfunction

    task automatic drive_req(input logic [31:0] a, input logic [31:0] d, input int size,
                             input bit uns, input bit wr);
        req_valid_i = 1'b1; req_addr_i = a; req_data_i = d;
        req_size_i = 2'(size); req_unsigned_i = uns; req_write_i = wr;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk_i);
            req_valid_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; stall_i = 1'b0; clear_i = 1'b0;
        end
    endtask

    // One request, issued without stall, acked the cycle after issue.
    task automatic single(input string tag, input logic [31:0] a, input logic [31:0] d, input int size,
                          input bit uns, input bit wr, input logic [31:0] rd,
                          input logic [3:0] esel, input logic [31:0] ewdat, input logic [31:0] ersp);
        @(negedge clk_i);
        drive_req(a, d, size, uns, wr);
        #1 chk({tag, ".ready"}, req_ready_o, 1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk({tag, ".cyc"}, cyc_o, 1);
        chk({tag, ".stb"}, stb_o, 1);
        chk({tag, ".adr"}, {2'b00, adr_o}, a >> 2);
        chk({tag, ".sel"}, sel_o, esel);
        chk({tag, ".we"}, we_o, wr);
        chk({tag, ".busy"}, busy_o, 1);
        if (wr) chk({tag, ".dat"}, master_dat_o, ewdat);
        @(negedge clk_i);
        chk({tag, ".stb_drop"}, stb_o, 0);
        ack_i = 1'b1; master_dat_i = rd;
        @(negedge clk_i);
        ack_i = 1'b0;
        chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
        chk({tag, ".rsp_data"}, rsp_data_o, ersp);
        chk({tag, ".rsp_err"}, {rsp_err_o, rsp_misaligned_o}, 0);
        @(negedge clk_i);
        chk({tag, ".rsp_pulse"}, rsp_valid_o, 0);
        chk({tag, ".cyc_drop"}, cyc_o, 0);
    endtask

    task automatic misaligned(input string tag, input logic [31:0] a, input int size);
        @(negedge clk_i);
        drive_req(a, 32'h1111_2222, size, 0, 0);
        #1 chk({tag, ".ready"}, req_ready_o, 1);
        @(negedge clk_i);
        req_valid_i = 1'b0;
        chk({tag, ".cyc"}, {cyc_o, stb_o}, 0);
        chk({tag, ".rsp_valid"}, rsp_valid_o, 1);
        chk({tag, ".rsp_mis"}, rsp_misaligned_o, 1);
        chk({tag, ".rsp_data"}, rsp_data_o, 0);
        @(negedge clk_i);
        chk({tag, ".rsp_pulse"}, rsp_valid_o, 0);
    endtask

    typedef struct {
        logic [31:0] addr;
        logic [31:0] wd;
        int          size;
        bit          uns;
        bit          wr;
        int          due;
    } txn_t;

    task automatic run_random();
        txn_t        acc_q[$];
        txn_t        iss_q[$];
        txn_t        t;
        bit          exp_v, exp_m, gen, mis, exp_rdy, done;
        logic [31:0] exp_d;
        int          out0, acc0;
        exp_v = 0; exp_m = 0; exp_d = 0; done = 0;
        for (int c = 0; c < NRAND + 300; c++) begin
            @(negedge clk_i);
            gen = c < NRAND;
            chk("r.rsp_valid", rsp_valid_o, exp_v);
            if (exp_v) begin
                chk("r.rsp_data", rsp_data_o, exp_d);
                chk("r.rsp_mis", rsp_misaligned_o, exp_m);
                chk("r.rsp_err", rsp_err_o, 0);
            end
            exp_v = 0; exp_m = 0; exp_d = 0;
            acc0 = acc_q.size();
            out0 = acc0 + iss_q.size();
            if (!gen && out0 == 0) begin
                done = 1;
                req_valid_i = 1'b0; ack_i = 1'b0; stall_i = 1'b0;
                break;
            end
            chk("r.stb", stb_o, acc0 != 0);
            if (out0 != 0) chk("r.cyc", cyc_o, 1);
            if (acc0 != 0) begin
                chk("r.adr", {2'b00, adr_o}, acc_q[0].addr >> 2);
                chk("r.sel", sel_o, ref_sel(acc_q[0].size, acc_q[0].addr));
                chk("r.we", we_o, acc_q[0].wr);
                if (acc_q[0].wr) chk("r.dat", master_dat_o, ref_wdat(acc_q[0].size, acc_q[0].wd));
            end
            // Slave: ack in order, no earlier than each transfer's due cycle.
            ack_i = 1'b0;
            master_dat_i = $urandom;
            if (iss_q.size() != 0 && iss_q[0].due <= c && $urandom_range(0, 9) < 6) begin
                t = iss_q.pop_front();
                ack_i = 1'b1;
                exp_v = 1;
                exp_d = t.wr ? 32'h0 : ref_load(t.size, t.uns, t.addr, master_dat_i);
            end
            stall_i = $urandom_range(0, 9) < 3;
            if (acc0 != 0 && !stall_i) begin
                t = acc_q.pop_front();
                t.due = c + int'($urandom_range(1, 3));
                iss_q.push_back(t);
            end
            // Master side request.
            req_valid_i = gen && ($urandom_range(0, 9) < 7);
            t.size = ($urandom_range(0, 9) == 0) ? 3 : int'($urandom_range(0, 2));
            t.addr = $urandom & 32'h0000_0FFF;
            if ($urandom_range(0, 9) != 0) begin
                if (t.size == 1) t.addr = t.addr & ~32'h1;
                if (t.size == 2) t.addr = t.addr & ~32'h3;
            end
            t.wd = $urandom; t.uns = 1'($urandom); t.wr = 1'($urandom); t.due = 0;
            req_addr_i = t.addr; req_data_i = t.wd; req_size_i = 2'(t.size);
            req_unsigned_i = t.uns; req_write_i = t.wr;
            #1;
            if (req_valid_i) begin
                mis = ref_mis(t.size, t.addr);
                exp_rdy = (out0 < DEPTH) && (acc0 == 0 || !stall_i) && (!mis || out0 == 0);
                chk("r.ready", req_ready_o, exp_rdy);
                if (req_ready_o) begin
                    if (mis) begin
                        exp_v = 1; exp_m = 1; exp_d = 0;
                    end else begin
                        acc_q.push_back(t);
                    end
                end
            end
        end
        if (!done) chk("r.drain_timeout", 0, 1);
        idle(2);
        chk("r.cyc_idle", {busy_o, cyc_o, stb_o}, 0);
    endtask

    initial begin
        rst_n_i = 1'b0; clear_i = 1'b0; ack_i = 1'b0; err_i = 1'b0; stall_i = 1'b0;
        master_dat_i = '0;
        drive_req(32'h100, 32'h0, 2, 0, 0);
        #13;
        chk("rst.bus", {cyc_o, stb_o, we_o, sel_o}, 0);
        chk("rst.rsp", {rsp_valid_o, rsp_err_o, rsp_misaligned_o, busy_o}, 0);
        chk("rst.ready", req_ready_o, 0);
        chk("rst.rsp_data", rsp_data_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1; req_valid_i = 1'b0;
        idle(2);

        single("wld",  32'h100, 32'h0,    2, 0, 0, 32'hDEADBEEF, 4'hF, 32'h0,        32'hDEADBEEF);
        single("sbld", 32'h103, 32'h0,    0, 0, 0, 32'h80FFFFFF, 4'h8, 32'h0,        32'hFFFFFF80);
        single("ubld", 32'h103, 32'h0,    0, 1, 0, 32'h80FFFFFF, 4'h8, 32'h0,        32'h00000080);
        single("hst",  32'h202, 32'h1234, 1, 0, 1, 32'hFFFFFFFF, 4'hC, 32'h12341234, 32'h0);
        single("bst",  32'h301, 32'hA7,   0, 0, 1, 32'h0,        4'h2, 32'hA7A7A7A7, 32'h0);
        single("shld", 32'h402, 32'h0,    1, 0, 0, 32'h9ABC0000, 4'hC, 32'h0,        32'hFFFF9ABC);

        misaligned("mis_w", 32'h101, 2);
        misaligned("mis_h", 32'h103, 1);
        misaligned("mis_11", 32'h100, 3);

        // Three loads in flight; err on the first flushes the rest.
        @(negedge clk_i); drive_req(32'h500, 0, 2, 0, 0);
        @(negedge clk_i); drive_req(32'h504, 0, 2, 0, 0);
        @(negedge clk_i); drive_req(32'h508, 0, 2, 0, 0);
        @(negedge clk_i); req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("err.pre_cyc", {cyc_o, stb_o}, 2'b10);
        err_i = 1'b1;
        @(negedge clk_i);
        err_i = 1'b0;
        chk("err.rsp", {rsp_valid_o, rsp_err_o, rsp_misaligned_o}, 3'b110);
        chk("err.bus", {cyc_o, stb_o}, 0);
        drive_req(32'h600, 0, 2, 0, 0);
        ack_i = 1'b1;
        #1 chk("err.flush_ready", req_ready_o, 0);
        req_valid_i = 1'b0;
        @(negedge clk_i);
        chk("err.late_ack", {rsp_valid_o, cyc_o}, 0);
        @(negedge clk_i);
        ack_i = 1'b0;
        chk("err.late_ack2", {rsp_valid_o, rsp_err_o}, 0);
        idle(1);

        // Clear mid-burst.
        @(negedge clk_i); drive_req(32'h700, 0, 2, 0, 0);
        @(negedge clk_i); drive_req(32'h704, 0, 2, 0, 1);
        @(negedge clk_i);
        clear_i = 1'b1; drive_req(32'h708, 0, 2, 0, 0);
        #1 chk("clr.ready", req_ready_o, 0);
        @(negedge clk_i);
        clear_i = 1'b0; req_valid_i = 1'b0;
        chk("clr.bus", {cyc_o, stb_o, we_o, sel_o}, 0);
        chk("clr.rsp", rsp_valid_o, 0);
        ack_i = 1'b1;
        @(negedge clk_i);
        chk("clr.ack_ignored", rsp_valid_o, 0);
        ack_i = 1'b0;
        @(negedge clk_i);
        chk("clr.ack_ignored2", {rsp_valid_o, cyc_o}, 0);
        idle(1);

        run_random();

        // Async reset while a store is held by stall.
        @(negedge clk_i); drive_req(32'h800, 32'hA5A5A5A5, 2, 0, 1);
        @(negedge clk_i); req_valid_i = 1'b0; stall_i = 1'b1;
        @(negedge clk_i);
        chk("rst2.stalled", {cyc_o, stb_o, we_o}, 3'b111);
        drive_req(32'h900, 0, 2, 0, 0);
        #2 rst_n_i = 1'b0;
        #1;
        chk("rst2.bus", {cyc_o, stb_o, we_o, sel_o, busy_o}, 0);
        chk("rst2.adr", {2'b00, adr_o}, 0);
        chk("rst2.dat", master_dat_o, 0);
        chk("rst2.ready", req_ready_o, 0);
        @(negedge clk_i);
        rst_n_i = 1'b1; req_valid_i = 1'b0; stall_i = 1'b0;
        idle(2);
        chk("rst2.after", {cyc_o, stb_o, rsp_valid_o}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
